// File: rtl/rename_status_file.sv
// rename_status_file
//   Per-architectural-register value + producer-tag store for the Tomasulo
//   issue stage. Source reads forward from the CDB in the same cycle; one
//   rename, one direct write and one CDB broadcast are absorbed per edge,
//   plus a global flush that squashes every pending producer.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rd_addr             RD_PORTS packed read addresses (port p: [p*AW +: AW])
//   rd_tag/rd_val/rd_ready  per-port producer tag, value, value-valid
//   ren_en/ren_addr/ren_tag destination rename
//   wr_en/wr_addr/wr_data   direct architectural write
//   cdb_valid/cdb_tag/cdb_data  common data bus broadcast
//   flush               clear all pending producer tags (values kept)
//   busy_count          registered count of entries with a pending producer
module rename_status_file #(
  parameter int NREGS    = 64,
  parameter int AW       = 6,
  parameter int TAG_W    = 8,
  parameter int WORD_W   = 32,
  parameter logic [TAG_W-1:0] NO_TAG = TAG_W'('h7F),
  parameter int RD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [RD_PORTS*AW-1:0]       rd_addr,
  output logic [RD_PORTS*TAG_W-1:0]    rd_tag,
  output logic [RD_PORTS*WORD_W-1:0]   rd_val,
  output logic [RD_PORTS-1:0]          rd_ready,
  input  logic                         ren_en,
  input  logic [AW-1:0]                ren_addr,
  input  logic [TAG_W-1:0]             ren_tag,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [WORD_W-1:0]            wr_data,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [WORD_W-1:0]            cdb_data,
  input  logic                         flush,
  output logic [AW:0]                  busy_count
);

  logic [TAG_W-1:0]  tags     [NREGS];
  logic [WORD_W-1:0] vals     [NREGS];
  logic [TAG_W-1:0]  tag_nxt  [NREGS];
  logic [WORD_W-1:0] val_nxt  [NREGS];
  logic [AW:0]       busy_nxt;
  logic [AW-1:0]     ra;
  logic              cdb_live;

  assign cdb_live = cdb_valid && (cdb_tag != NO_TAG);

  // Source reads see pre-edge state; only the CDB is forwarded.
  always_comb begin
    rd_tag   = '0;
    rd_val   = '0;
    rd_ready = '0;
    ra       = '0;
    for (int unsigned p = 0; p < RD_PORTS; p++) begin
      ra = rd_addr[p*AW +: AW];
      if (int'(ra) >= NREGS) begin
        rd_tag[p*TAG_W +: TAG_W]   = NO_TAG;
        rd_val[p*WORD_W +: WORD_W] = '0;
        rd_ready[p]                = 1'b1;
      end else if (tags[ra] == NO_TAG) begin
        rd_tag[p*TAG_W +: TAG_W]   = NO_TAG;
        rd_val[p*WORD_W +: WORD_W] = vals[ra];
        rd_ready[p]                = 1'b1;
      end else if (cdb_live && (tags[ra] == cdb_tag)) begin
        rd_tag[p*TAG_W +: TAG_W]   = NO_TAG;
        rd_val[p*WORD_W +: WORD_W] = cdb_data;
        rd_ready[p]                = 1'b1;
      end else begin
        rd_tag[p*TAG_W +: TAG_W]   = tags[ra];
        rd_val[p*WORD_W +: WORD_W] = vals[ra];
        rd_ready[p]                = 1'b0;
      end
    end
  end

  // Value and tag are resolved independently: the value takes the direct
  // write over the CDB even under flush or rename, while the tag follows
  // flush > rename > (write | CDB clear). Addresses >= NREGS never match i.
  always_comb begin
    tag_nxt  = tags;
    val_nxt  = vals;
    busy_nxt = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (wr_en && (wr_addr == AW'(i)))
        val_nxt[i] = wr_data;
      else if (cdb_live && (tags[i] == cdb_tag))
        val_nxt[i] = cdb_data;

      if (flush)
        tag_nxt[i] = NO_TAG;
      else if (ren_en && (ren_addr == AW'(i)))
        tag_nxt[i] = ren_tag;
      else if ((wr_en && (wr_addr == AW'(i))) || (cdb_live && (tags[i] == cdb_tag)))
        tag_nxt[i] = NO_TAG;

      if (tag_nxt[i] != NO_TAG)
        busy_nxt = busy_nxt + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        tags[i] <= NO_TAG;
        vals[i] <= '0;
      end
      busy_count <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        tags[i] <= tag_nxt[i];
        vals[i] <= val_nxt[i];
      end
      busy_count <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_rename_status_file.sv
// Testbench for rename_status_file: directed vectors, a reference model of
// the register/tag store, a per-cycle compare process and literal checks.
module tb_rename_status_file;
  localparam int NREGS = 64;
  localparam int AW = 6;
  localparam int TAG_W = 8;
  localparam int WORD_W = 32;
  localparam logic [7:0] NT = 8'h7F;
  localparam int RP = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [RP*AW-1:0] rd_addr;
  logic [RP*TAG_W-1:0] rd_tag;
  logic [RP*WORD_W-1:0] rd_val;
  logic [RP-1:0] rd_ready;
  logic ren_en, wr_en, cdb_valid, flush;
  logic [AW-1:0] ren_addr, wr_addr;
  logic [TAG_W-1:0] ren_tag, cdb_tag;
  logic [WORD_W-1:0] wr_data, cdb_data;
  logic [AW:0] busy_count;

  int nvec = 0;
  int nerr = 0;

  rename_status_file #(.NREGS(NREGS), .AW(AW), .TAG_W(TAG_W), .WORD_W(WORD_W),
                       .NO_TAG(NT), .RD_PORTS(RP)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_tag(rd_tag), .rd_val(rd_val),
    .rd_ready(rd_ready), .ren_en(ren_en), .ren_addr(ren_addr), .ren_tag(ren_tag),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .flush(flush), .busy_count(busy_count));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural state after each edge.
  logic [7:0]  m_tag [NREGS];
  logic [31:0] m_val [NREGS];

  always @(posedge clk or negedge rst_n) begin
    logic [7:0]  t [NREGS];
    logic [31:0] v [NREGS];
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        m_tag[i] <= NT;
        m_val[i] <= '0;
      end
    end else begin
      t = m_tag;
      v = m_val;
      // apply effects lowest priority first so later ones override
      if (cdb_valid && cdb_tag != NT)
        for (int i = 0; i < NREGS; i++)
          if (m_tag[i] == cdb_tag) begin
            v[i] = cdb_data;
            t[i] = NT;
          end
      if (wr_en) begin
        v[wr_addr] = wr_data;
        t[wr_addr] = NT;
      end
      if (ren_en) t[ren_addr] = ren_tag;
      if (flush) for (int i = 0; i < NREGS; i++) t[i] = NT;
      m_tag <= t;
      m_val <= v;
    end
  end

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    int busy;
    logic [5:0] a;
    logic [7:0] et;
    logic [31:0] ev;
    logic er;
    busy = 0;
    for (int i = 0; i < NREGS; i++) if (m_tag[i] != NT) busy++;
    chk("busy_count", 64'(busy_count), 64'(busy));
    for (int p = 0; p < RP; p++) begin
      a = rd_addr[p*AW +: AW];
      if (m_tag[a] == NT) begin
        et = NT; ev = m_val[a]; er = 1'b1;
      end else if (cdb_valid && cdb_tag != NT && cdb_tag == m_tag[a]) begin
        et = NT; ev = cdb_data; er = 1'b1;
      end else begin
        et = m_tag[a]; ev = m_val[a]; er = 1'b0;
      end
      chk($sformatf("rd%0d_tag", p), 64'(rd_tag[p*TAG_W +: TAG_W]), 64'(et));
      chk($sformatf("rd%0d_val", p), 64'(rd_val[p*WORD_W +: WORD_W]), 64'(ev));
      chk($sformatf("rd%0d_ready", p), 64'(rd_ready[p]), 64'(er));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    ren_en = 0; wr_en = 0; cdb_valid = 0; flush = 0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {6'(a1), 6'(a0)};
  endtask

  task automatic ren(input int a, input int t);
    ren_en = 1; ren_addr = 6'(a); ren_tag = 8'(t);
  endtask

  task automatic lit(input string nm, input int p, input logic [7:0] t,
                     input logic [31:0] v, input logic r);
    chk({nm, "_tag"}, 64'(rd_tag[p*TAG_W +: TAG_W]), 64'(t));
    chk({nm, "_val"}, 64'(rd_val[p*WORD_W +: WORD_W]), 64'(v));
    chk({nm, "_rdy"}, 64'(rd_ready[p]), 64'(r));
  endtask

  initial begin
    rst_n = 0;
    ren_en = 0; wr_en = 0; cdb_valid = 0; flush = 0;
    ren_addr = '0; ren_tag = '0; wr_addr = '0; wr_data = '0;
    cdb_tag = '0; cdb_data = '0;
    set_rd(0, 0);
    repeat (2) cyc();
    rst_n = 1;
    // 1: reset state
    set_rd(5, 63); #1;
    lit("t1_r5", 0, NT, 0, 1);
    lit("t1_r63", 1, NT, 0, 1);
    chk("t1_busy", 64'(busy_count), 0);
    // 2: rename r3, then forward and commit -17
    ren(3, 2); cyc();
    set_rd(3, 5); #1;
    lit("t2_pend", 0, 8'h02, 0, 0);
    chk("t2_busy1", 64'(busy_count), 1);
    cdb_valid = 1; cdb_tag = 8'h02; cdb_data = -32'sd17; #1;
    lit("t2_fwd", 0, NT, 32'hFFFF_FFEF, 1);
    cyc();
    #1;
    lit("t2_done", 0, NT, 32'hFFFF_FFEF, 1);
    chk("t2_busy0", 64'(busy_count), 0);
    // 3: two entries share a tag
    ren(1, 5); cyc();
    ren(4, 5); cyc();
    chk("t3_busy2", 64'(busy_count), 2);
    cdb_valid = 1; cdb_tag = 8'h05; cdb_data = 99; cyc();
    set_rd(1, 4); #1;
    lit("t3_r1", 0, NT, 99, 1);
    lit("t3_r4", 1, NT, 99, 1);
    // 4: rename collides with CDB on same entry
    ren(2, 3); cyc();
    ren(2, 6); cdb_valid = 1; cdb_tag = 8'h03; cdb_data = 7;
    set_rd(2, 1); #1;
    lit("t4_fwd", 0, NT, 7, 1);
    cyc();
    #1;
    lit("t4_after", 0, 8'h06, 7, 0);
    chk("t4_busy", 64'(busy_count), 1);
    // CDB tag equal to NO_TAG is not a broadcast
    cdb_valid = 1; cdb_tag = NT; cdb_data = 55; set_rd(1, 2); #1;
    lit("t4_notag", 0, NT, 99, 1);
    cyc();
    // write and CDB to same entry: write wins
    ren(5, 9); cyc();
    wr_en = 1; wr_addr = 5; wr_data = 1; cdb_valid = 1; cdb_tag = 8'h09; cdb_data = 2; cyc();
    set_rd(5, 2); #1;
    lit("t4_wrwin", 0, NT, 1, 1);
    // 5: flush beats rename, values retained
    wr_en = 1; wr_addr = 8; wr_data = 111; cyc();
    ren(8, 1); cyc();
    ren(9, 2); cyc();
    ren(10, 3); cyc();
    chk("t5_busy4", 64'(busy_count), 4);
    flush = 1; ren(11, 4); cyc();
    set_rd(8, 11); #1;
    chk("t5_busy0", 64'(busy_count), 0);
    lit("t5_r8", 0, NT, 111, 1);
    lit("t5_r11", 1, NT, 0, 1);
    // 6: asynchronous reset mid-cycle
    ren(12, 8'h10); cyc();
    ren(13, 8'h11); cyc();
    ren(14, 8'h12); cyc();
    chk("t6_busy3", 64'(busy_count), 3);
    set_rd(12, 8);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_busy", 64'(busy_count), 0);
    lit("t6_rst_r12", 0, NT, 0, 1);
    lit("t6_rst_r8", 1, NT, 0, 1);
    repeat (2) cyc();
    rst_n = 1;
    wr_en = 1; wr_addr = 7; wr_data = 12345; cyc();
    set_rd(7, 12); #1;
    lit("t6_r7", 0, NT, 12345, 1);
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
